// File: rtl/timer_time_counter_if.sv
// ---------------------------------------------------------------------------
// timer_time_counter_if
//
// Bundles the host-side signals of the microsecond timer / timestamp block.
//
//   timer_nwr        active-low timer write strobe (level sensitive)
//   timer_value      timer period in microseconds, taken while timer_nwr low
//   interrupt        timer interrupt request (registered in the block)
//   interrupt_clear  active-high interrupt acknowledge
//   time_nrd         active-low time read strobe; freezes time_value while low
//   time_value       microsecond timestamp (registered in the block)
//
// The master modport is the host (or testbench) side; the slave modport is
// the timer block itself.
// ---------------------------------------------------------------------------
interface timer_time_counter_if;

    logic        timer_nwr;
    logic [31:0] timer_value;
    logic        interrupt;
    logic        interrupt_clear;
    logic        time_nrd;
    logic [31:0] time_value;

    modport master (
        output timer_nwr,
        output timer_value,
        output interrupt_clear,
        output time_nrd,
        input  interrupt,
        input  time_value
    );

    modport slave (
        input  timer_nwr,
        input  timer_value,
        input  interrupt_clear,
        input  time_nrd,
        output interrupt,
        output time_value
    );

endinterface : timer_time_counter_if

// File: rtl/timer_time_counter.sv
// ---------------------------------------------------------------------------
// timer_time_counter
//
// Microsecond time base with a free-running timestamp and a periodic timer.
//
// A prescaler divides clk by MHZ_TIMER_VALUE to produce a one-cycle tick
// every microsecond. Each tick advances a 32-bit timestamp counter and, when
// the timer is enabled, decrements a 32-bit down-counter. When the
// down-counter expires it reloads from the reload register and raises the
// interrupt, giving an interrupt period of exactly "reload" microseconds.
//
// Ports:
//   clk     system clock, all state changes on the rising edge
//   nreset  asynchronous active-low reset, clears every register
//   bus     timer_time_counter_if.slave
//             timer_nwr / timer_value    : load reload + down-counter
//             interrupt / interrupt_clear: sticky request and acknowledge
//             time_nrd / time_value      : snapshot read of the timestamp
//
// Parameters:
//   MHZ_TIMER_BITS   width of the prescaler counter
//   MHZ_TIMER_VALUE  clk cycles per microsecond, 1 .. 2**MHZ_TIMER_BITS-1
// ---------------------------------------------------------------------------
module timer_time_counter #(
    parameter int MHZ_TIMER_BITS  = 8,
    parameter int MHZ_TIMER_VALUE = 27
) (
    input  logic                 clk,
    input  logic                 nreset,
    timer_time_counter_if.slave  bus
);

    // Last prescaler count before the wrap; the tick fires on this count.
    localparam logic [MHZ_TIMER_BITS-1:0] PRESC_LAST =
        MHZ_TIMER_BITS'(MHZ_TIMER_VALUE - 1);
    localparam logic [MHZ_TIMER_BITS-1:0] PRESC_ONE  = MHZ_TIMER_BITS'(1);
    localparam logic [MHZ_TIMER_BITS-1:0] PRESC_ZERO = {MHZ_TIMER_BITS{1'b0}};

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [MHZ_TIMER_BITS-1:0] presc_r;     // microsecond prescaler
    logic [31:0]               time_cnt_r;  // free-running timestamp
    logic [31:0]               time_val_r;  // timestamp as presented to host
    logic [31:0]               reload_r;    // timer period, 0 = disabled
    logic [31:0]               down_r;      // microseconds left in period
    logic                      irq_r;       // sticky interrupt request

    // -----------------------------------------------------------------------
    // Next-state signals
    // -----------------------------------------------------------------------
    logic                      tick_s;
    logic                      expire_s;
    logic [MHZ_TIMER_BITS-1:0] presc_nxt_s;
    logic [31:0]               time_cnt_nxt_s;
    logic [31:0]               time_val_nxt_s;
    logic [31:0]               reload_nxt_s;
    logic [31:0]               down_nxt_s;
    logic                      irq_nxt_s;

    // Prescaler: count 0..MHZ_TIMER_VALUE-1, tick on the last count.
    always_comb begin
        tick_s      = 1'b0;
        presc_nxt_s = presc_r;
        if (presc_r == PRESC_LAST) begin
            tick_s      = 1'b1;
            presc_nxt_s = PRESC_ZERO;
        end else begin
            tick_s      = 1'b0;
            presc_nxt_s = presc_r + PRESC_ONE;
        end
    end

    // Timestamp: advance once per tick, wrapping silently at 2**32.
    always_comb begin
        time_cnt_nxt_s = time_cnt_r;
        if (tick_s) begin
            time_cnt_nxt_s = time_cnt_r + 32'd1;
        end else begin
            time_cnt_nxt_s = time_cnt_r;
        end
    end

    // Read snapshot: follow the counter while time_nrd is high, freeze while
    // it is low so the host sees one stable value for the whole strobe.
    // The copy lags the counter by one clk.
    always_comb begin
        time_val_nxt_s = time_val_r;
        if (bus.time_nrd) begin
            time_val_nxt_s = time_cnt_r;
        end else begin
            time_val_nxt_s = time_val_r;
        end
    end

    // Timer expiry: a tick lands on the final microsecond of an enabled
    // period. A write in the same cycle takes priority, so the tick is lost
    // to the timer. The "<= 1" compare also catches a zero down-counter with
    // a non-zero reload, a state a write can never produce, so the timer
    // cannot run away through a 2**32 wrap.
    always_comb begin
        expire_s = 1'b0;
        if (bus.timer_nwr && tick_s && (reload_r != 32'd0) &&
            (down_r <= 32'd1)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    // Timer state: load on write, else reload-or-decrement on each enabled
    // tick. A zero reload parks the down-counter at zero.
    always_comb begin
        reload_nxt_s = reload_r;
        down_nxt_s   = down_r;
        if (!bus.timer_nwr) begin
            reload_nxt_s = bus.timer_value;
            down_nxt_s   = bus.timer_value;
        end else if (expire_s) begin
            reload_nxt_s = reload_r;
            down_nxt_s   = reload_r;
        end else if (tick_s && (reload_r != 32'd0)) begin
            reload_nxt_s = reload_r;
            down_nxt_s   = down_r - 32'd1;
        end else begin
            reload_nxt_s = reload_r;
            down_nxt_s   = down_r;
        end
    end

    // Interrupt: a write clears it; an expiry sets it and beats a coincident
    // acknowledge; otherwise an acknowledge clears it. Repeated expiries while
    // already set leave it set with no overflow indication.
    always_comb begin
        irq_nxt_s = irq_r;
        if (!bus.timer_nwr) begin
            irq_nxt_s = 1'b0;
        end else if (expire_s) begin
            irq_nxt_s = 1'b1;
        end else if (bus.interrupt_clear) begin
            irq_nxt_s = 1'b0;
        end else begin
            irq_nxt_s = irq_r;
        end
    end

    // State registers; nreset clears everything, aborting any running period.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            presc_r    <= PRESC_ZERO;
            time_cnt_r <= 32'd0;
            time_val_r <= 32'd0;
            reload_r   <= 32'd0;
            down_r     <= 32'd0;
            irq_r      <= 1'b0;
        end else begin
            presc_r    <= presc_nxt_s;
            time_cnt_r <= time_cnt_nxt_s;
            time_val_r <= time_val_nxt_s;
            reload_r   <= reload_nxt_s;
            down_r     <= down_nxt_s;
            irq_r      <= irq_nxt_s;
        end
    end

    // Outputs come straight from registers.
    assign bus.interrupt  = irq_r;
    assign bus.time_value = time_val_r;

endmodule : timer_time_counter

// File: tb/tb_timer_time_counter.sv
// ---------------------------------------------------------------------------
// tb_timer_time_counter
//
// Self-checking bench for timer_time_counter with MHZ_TIMER_VALUE = 4.
// The reference model works from absolute time: it counts clk edges since
// reset release, derives the microsecond count as edges / MHZ, and decides
// timer expiry from the number of ticks elapsed since the last write.
// ---------------------------------------------------------------------------
module tb_timer_time_counter;

    localparam int MHZ  = 4;
    localparam int BITS = 8;

    logic clk;
    logic nreset;

    timer_time_counter_if bus();

    timer_time_counter #(
        .MHZ_TIMER_BITS  (BITS),
        .MHZ_TIMER_VALUE (MHZ)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint      m_edges  = 0;      // rising edges since reset release
    longint      m_wtick  = 0;      // tick index at the last timer write
    logic [31:0] m_time   = 32'd0;  // microsecond counter
    logic [31:0] m_tv     = 32'd0;  // expected time_value
    logic [31:0] m_reload = 32'd0;  // programmed period
    logic        m_irq    = 1'b0;   // expected interrupt

    // True when tick number t (with tick flag tk) ends a timer period.
    function automatic bit expires(longint t, bit tk);
        if (!tk || m_reload == 32'd0 || t <= m_wtick) return 1'b0;
        return ((t - m_wtick) % longint'(m_reload)) == 0;
    endfunction

    function automatic bit next_edge_expires();
        longint e;
        e = m_edges + 1;
        return expires(e / MHZ, (e % MHZ) == 0);
    endfunction

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_edges  = 0;
            m_wtick  = 0;
            m_time   = 32'd0;
            m_tv     = 32'd0;
            m_reload = 32'd0;
            m_irq    = 1'b0;
        end else begin
            logic [31:0] prev;
            longint      t;
            bit          tk;
            prev    = m_time;
            m_edges = m_edges + 1;
            tk      = (m_edges % MHZ) == 0;
            t       = m_edges / MHZ;
            if (bus.time_nrd) m_tv = prev;
            if (tk) m_time = m_time + 32'd1;
            if (!bus.timer_nwr) begin
                m_reload = bus.timer_value;
                m_wtick  = t;
                m_irq    = 1'b0;
            end else if (expires(t, tk)) begin
                m_irq = 1'b1;
            end else if (bus.interrupt_clear) begin
                m_irq = 1'b0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic apply_reset();
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #7;
        checks++;
        if (bus.time_value !== 32'd0) begin
            errors++;
            $display("FAIL reset_time_value got %h exp %h", bus.time_value, 32'd0);
        end
        checks++;
        if (bus.interrupt !== 1'b0) begin
            errors++;
            $display("FAIL reset_interrupt got %b exp %b", bus.interrupt, 1'b0);
        end
    endtask

    task automatic test_time_base();
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 40; i++) @(negedge clk);
        checks++;
        if (bus.time_value !== m_tv) begin
            errors++;
            $display("FAIL time_base_model got %0d exp %0d", bus.time_value, m_tv);
        end
        checks++;
        if (bus.time_value < 32'd9 || bus.time_value > 32'd11) begin
            errors++;
            $display("FAIL time_base_range got %0d exp 9..11", bus.time_value);
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] held;
        int          bad;
        held = bus.time_value;
        bus.time_nrd = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.time_value !== held) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL snapshot_hold got %0d changed cycles exp 0", bad);
        end
        bus.time_nrd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.time_value < held + 32'd4 || bus.time_value > held + 32'd6) begin
            errors++;
            $display("FAIL snapshot_jump got %0d exp %0d..%0d",
                     bus.time_value, held + 32'd4, held + 32'd6);
        end
        checks++;
        if (bus.time_value !== m_tv) begin
            errors++;
            $display("FAIL snapshot_model got %0d exp %0d", bus.time_value, m_tv);
        end
    endtask

    task automatic test_timer_period();
        int n;
        int k;
        bus.timer_nwr   = 1'b0;
        bus.timer_value = 32'd3;
        @(negedge clk);
        bus.timer_nwr = 1'b1;
        n = 0;
        while (bus.interrupt !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 8 || n > 16) begin
            errors++;
            $display("FAIL period_first_rise got %0d clks exp 8..16", n);
        end
        checks++;
        if (bus.interrupt !== m_irq) begin
            errors++;
            $display("FAIL period_first_model got %b exp %b", bus.interrupt, m_irq);
        end
        bus.interrupt_clear = 1'b1;
        @(negedge clk);
        bus.interrupt_clear = 1'b0;
        k = 1;
        checks++;
        if (bus.interrupt !== 1'b0) begin
            errors++;
            $display("FAIL period_cleared got %b exp %b", bus.interrupt, 1'b0);
        end
        while (bus.interrupt !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 12) begin
            errors++;
            $display("FAIL period_interval got %0d clks exp 12", k);
        end
    endtask

    task automatic test_clear_collision();
        int  n;
        bit  found;
        int  bad;
        bus.interrupt_clear = 1'b1;
        @(negedge clk);
        bus.interrupt_clear = 1'b0;
        checks++;
        if (bus.interrupt !== 1'b0) begin
            errors++;
            $display("FAIL clear_one_clk got %b exp %b", bus.interrupt, 1'b0);
        end
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            if (next_edge_expires()) found = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL collision_wait got timeout exp expiry within 40 clks");
        end
        bus.interrupt_clear = 1'b1;
        @(negedge clk);
        bus.interrupt_clear = 1'b0;
        checks++;
        if (bus.interrupt !== 1'b1) begin
            errors++;
            $display("FAIL collision_set_wins got %b exp %b", bus.interrupt, 1'b1);
        end
        bus.timer_nwr   = 1'b0;
        bus.timer_value = 32'd0;
        @(negedge clk);
        bus.timer_nwr = 1'b1;
        checks++;
        if (bus.interrupt !== 1'b0) begin
            errors++;
            $display("FAIL disable_clears got %b exp %b", bus.interrupt, 1'b0);
        end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.interrupt !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL disable_stays_off got %0d set cycles exp 0", bad);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if (bus.time_value !== m_tv) begin
                errors++;
                $display("FAIL random_time_value cycle %0d got %h exp %h",
                         i, bus.time_value, m_tv);
            end
            checks++;
            if (bus.interrupt !== m_irq) begin
                errors++;
                $display("FAIL random_interrupt cycle %0d got %b exp %b",
                         i, bus.interrupt, m_irq);
            end
            bus.time_nrd        = ($urandom_range(0, 99) < 70);
            bus.timer_nwr       = ($urandom_range(0, 99) >= 4);
            bus.timer_value     = 32'($urandom_range(0, 6));
            bus.interrupt_clear = ($urandom_range(0, 9) == 0);
            if (!nreset) nreset = 1'b1;
            else if ($urandom_range(0, 599) == 0) nreset = 1'b0;
        end
        bus.time_nrd        = 1'b1;
        bus.timer_nwr       = 1'b1;
        bus.interrupt_clear = 1'b0;
        nreset              = 1'b1;
    endtask

    task automatic test_wrap();
        int n;
        bit saw_ff;
        bit saw_wrap;
        apply_reset();
        n = 0;
        while (!((m_edges % MHZ) == 0 && m_edges > 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        force dut.time_cnt_r = 32'hFFFF_FFFF;
        m_time = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.time_cnt_r;
        saw_ff   = 1'b0;
        saw_wrap = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (bus.time_value !== m_tv) begin
                errors++;
                $display("FAIL wrap_model cycle %0d got %h exp %h", i, bus.time_value, m_tv);
            end
            if (bus.time_value === 32'hFFFF_FFFF) saw_ff = 1'b1;
            if (saw_ff && bus.time_value === 32'h0000_0000) saw_wrap = 1'b1;
        end
        checks++;
        if (!saw_wrap) begin
            errors++;
            $display("FAIL wrap_to_zero got %h exp 00000000 after ffffffff", bus.time_value);
        end
    endtask

    task automatic test_async_reset();
        int n;
        apply_reset();
        bus.timer_nwr   = 1'b0;
        bus.timer_value = 32'd5;
        @(negedge clk);
        bus.timer_nwr = 1'b1;
        n = 0;
        while (m_tv !== 32'h0000_1234 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        bus.time_nrd = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.time_value !== 32'h0000_1234) begin
            errors++;
            $display("FAIL async_pre_time got %h exp %h", bus.time_value, 32'h0000_1234);
        end
        checks++;
        if (bus.interrupt !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_irq got %b exp %b", bus.interrupt, 1'b1);
        end
        #2;
        nreset = 1'b0;
        #1;
        checks++;
        if (bus.time_value !== 32'd0) begin
            errors++;
            $display("FAIL async_time_value got %h exp %h", bus.time_value, 32'd0);
        end
        checks++;
        if (bus.interrupt !== 1'b0) begin
            errors++;
            $display("FAIL async_interrupt got %b exp %b", bus.interrupt, 1'b0);
        end
        @(negedge clk);
        bus.time_nrd = 1'b1;
        nreset       = 1'b1;
        for (int i = 0; i < 30; i++) @(negedge clk);
        checks++;
        if (bus.interrupt !== 1'b0) begin
            errors++;
            $display("FAIL reset_disables_timer got %b exp %b", bus.interrupt, 1'b0);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        nreset              = 1'b0;
        bus.timer_nwr       = 1'b1;
        bus.timer_value     = 32'd0;
        bus.interrupt_clear = 1'b0;
        bus.time_nrd        = 1'b1;
        test_reset();
        test_time_base();
        test_snapshot();
        test_timer_period();
        test_clear_collision();
        test_random();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_timer_time_counter

// File: doc/timer_time_counter.md
TIMER_TIME_COUNTER -- requirements
Module: timer_time_counter

Interface
REQ-001 Parameter MHZ_TIMER_BITS, default 8: width of the microsecond prescaler counter.
REQ-002 Parameter MHZ_TIMER_VALUE, default 27: clk cycles per microsecond tick; range 1..2^MHZ_TIMER_BITS-1.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 nreset  input  1  asynchronous, active-low reset.
REQ-005 timer_nwr  input  1  active-low timer write strobe, level-sensitive.
REQ-006 timer_value  input  32  timer period in microseconds, sampled while timer_nwr low.
REQ-007 interrupt  output  1  timer interrupt request, registered.
REQ-008 interrupt_clear  input  1  active-high interrupt acknowledge.
REQ-009 time_nrd  input  1  active-low time read strobe.
REQ-010 time_value  output  32  microsecond timestamp, registered.

Function
REQ-011 Prescaler counts 0..MHZ_TIMER_VALUE-1 and wraps to 0; tick pulses one clk cycle on the cycle the counter equals MHZ_TIMER_VALUE-1.
- One tick every MHZ_TIMER_VALUE clk cycles.
- Prescaler is free-running and unaffected by timer_nwr or time_nrd.
REQ-012 Time counter: 32-bit up-counter, +1 per tick, wraps 0xFFFFFFFF -> 0 with no flag.
REQ-013 time_value register behaviour:
- While time_nrd high: time_value <= time counter each clk.
- While time_nrd low: time_value holds its value, giving a stable snapshot for the whole read strobe.
- The time counter keeps counting during the hold.
REQ-014 Timer state: 32-bit reload register and 32-bit down-counter.
REQ-015 Timer write, on each clk with timer_nwr low:
- reload <= timer_value and down-counter <= timer_value.
- interrupt <= 0.
- A tick in the same cycle is ignored by the timer.
REQ-016 Reload = 0 disables the timer: down-counter stays 0, interrupt never set.
REQ-017 Timer tick with reload != 0 and timer_nwr high:
- Down-counter == 1: down-counter <= reload and interrupt <= 1.
- Otherwise: down-counter decrements by 1.
- Resulting period is exactly reload microseconds.
REQ-018 interrupt stays set until cleared: interrupt_clear high on a clk edge clears it.
REQ-019 Simultaneous set (REQ-017) and interrupt_clear: set wins, interrupt = 1.
REQ-020 Further expiries while interrupt is already 1 keep it at 1; no counting or overflow indication.
REQ-021 Latency:
- interrupt rises on the clk edge of the expiring tick.
- time_value reflects a tick one clk after the counter updates.

Reset
REQ-022 nreset low asynchronously forces all registers to 0: prescaler, time counter, time_value, reload, down-counter, interrupt.
REQ-023 Reset mid-operation aborts any pending period; after release the timer stays disabled until written.
REQ-024 After nreset deasserts, counting resumes from 0 on the next clk edge, with the first tick MHZ_TIMER_VALUE cycles later.

Verification
REQ-025 Time base, MHZ_TIMER_VALUE=4: release reset, run 40 clks with time_nrd high -> time_value = 10 (±1 for the REQ-021 pipeline).
REQ-026 Snapshot: hold time_nrd low for 20 clks -> time_value constant; set time_nrd high -> time_value jumps by 5 (±1) within 2 clks.
REQ-027 Timer period: pulse timer_nwr low for 1 clk with timer_value=3, MHZ_TIMER_VALUE=4 -> interrupt rises 12 clks (±4 by prescaler phase) later; after clearing, it rises again exactly 12 clks after the previous rise.
REQ-028 Clear and collision:
- interrupt_clear for 1 clk -> interrupt 0 on the next edge.
- interrupt_clear on the expiry cycle -> interrupt stays 1.
- Write timer_value=0 -> interrupt 0 and it never reasserts.
REQ-029 Async reset: assert nreset between clk edges with interrupt=1 and time_value=0x1234 -> both read 0 immediately, before any clk edge.
REQ-030 Wrap: force the time counter to 0xFFFFFFFF -> after the next tick time_value = 0x00000000.
